// File: rtl/sat_ammo_counter.sv
// Saturating ammo counter: load, fire-by-rate and increment toward a loadable ceiling.
// One clock of latency on every count/ceiling update; async reset forces out=0, max=all ones.

// N-bit register with asynchronous active-high reset to a parameterised value.
module DFF #(
   parameter int            W       = 9,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_o <= RST_VAL;
      else     q_o <= d_i;
   end
endmodule

// Two-input AND-OR mux; sel_i must be one-hot.
module Mux2 #(
   parameter int W = 9
) (
   input  logic [1:0]   sel_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = ({W{sel_i[0]}} & a_i) | ({W{sel_i[1]}} & b_i);
endmodule

// Four-input AND-OR mux; sel_i must be one-hot.
module Mux4 #(
   parameter int W = 9
) (
   input  logic [3:0]   sel_i,
   input  logic [W-1:0] d0_i,
   input  logic [W-1:0] d1_i,
   input  logic [W-1:0] d2_i,
   input  logic [W-1:0] d3_i,
   output logic [W-1:0] y_o
);
   assign y_o = ({W{sel_i[0]}} & d0_i) | ({W{sel_i[1]}} & d1_i) |
                ({W{sel_i[2]}} & d2_i) | ({W{sel_i[3]}} & d3_i);
endmodule

module sat_ammo_counter #(
   parameter int N = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up,
   input  logic         down,
   input  logic         load,
   input  logic [1:0]   load_max,
   input  logic [N-1:0] in,
   input  logic [N-1:0] rate,
   output logic [N-1:0] out,
   output logic [N-1:0] max,
   output logic         empty,
   output logic         full
);
   logic [N-1:0] cnt_q, cnt_d, max_q, max_d;
   logic [N-1:0] cnt_plus1, cnt_minus, inc_val, dec_val;
   logic [3:0]   cnt_sel;
   logic [1:0]   max_sel, inc_sel, dec_sel;
   logic         at_ceiling, underflow, max_wr;

   assign at_ceiling = (cnt_q >= max_q);
   assign underflow  = (rate > cnt_q);
   assign cnt_plus1  = cnt_q + {{(N-1){1'b0}}, 1'b1};
   assign cnt_minus  = cnt_q - rate;

   // Only reached when cnt_q < max_q, so cnt_plus1 cannot wrap.
   assign inc_sel = {at_ceiling, ~at_ceiling};
   Mux2 #(.W(N)) u_inc (.sel_i(inc_sel), .a_i(cnt_plus1), .b_i(max_q), .y_o(inc_val));

   assign dec_sel = {underflow, ~underflow};
   Mux2 #(.W(N)) u_dec (.sel_i(dec_sel), .a_i(cnt_minus), .b_i({N{1'b0}}), .y_o(dec_val));

   // Priority encoder: load > down > up > hold, always exactly one bit set.
   assign cnt_sel[3] = load;
   assign cnt_sel[2] = ~load & down;
   assign cnt_sel[1] = ~load & ~down & up;
   assign cnt_sel[0] = ~load & ~down & ~up;

   Mux4 #(.W(N)) u_cnt_mux (
      .sel_i (cnt_sel),
      .d0_i  (cnt_q),
      .d1_i  (inc_val),
      .d2_i  (dec_val),
      .d3_i  (in),
      .y_o   (cnt_d)
   );

   assign max_wr  = (load_max == 2'b10);
   assign max_sel = {max_wr, ~max_wr};
   Mux2 #(.W(N)) u_max_mux (.sel_i(max_sel), .a_i(max_q), .b_i(in), .y_o(max_d));

   DFF #(.W(N), .RST_VAL({N{1'b0}})) u_cnt_reg (.clk(clk), .rst(rst), .d_i(cnt_d), .q_o(cnt_q));
   DFF #(.W(N), .RST_VAL({N{1'b1}})) u_max_reg (.clk(clk), .rst(rst), .d_i(max_d), .q_o(max_q));

   assign out   = cnt_q;
   assign max   = max_q;
   assign empty = (cnt_q == {N{1'b0}});
   assign full  = at_ceiling;
endmodule

// File: tb/tb_sat_ammo_counter.sv
// Randomised and directed checks of sat_ammo_counter against a plain-arithmetic model.
module tb_sat_ammo_counter;
   localparam int N = 9;
   localparam int ALL1 = (1 << N) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         up = 1'b0, down = 1'b0, load = 1'b0;
   logic [1:0]   load_max = 2'b00;
   logic [N-1:0] in = '0, rate = '0;
   logic [N-1:0] out, max;
   logic         empty, full;

   int checks = 0;
   int failures = 0;
   int m_out, m_max;

   sat_ammo_counter #(.N(N)) dut (
      .clk(clk), .rst(rst), .up(up), .down(down), .load(load),
      .load_max(load_max), .in(in), .rate(rate),
      .out(out), .max(max), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".out"},   32'(out),   32'(m_out));
      chk({tag, ".max"},   32'(max),   32'(m_max));
      chk({tag, ".empty"}, 32'(empty), 32'(m_out == 0));
      chk({tag, ".full"},  32'(full),  32'(m_out >= m_max));
   endtask

   task automatic drive(input logic u, input logic d, input logic l, input logic [1:0] lm,
                        input int din, input int r);
      up = u; down = d; load = l; load_max = lm; in = N'(din); rate = N'(r);
   endtask

   // Model evaluated on the pre-edge state and inputs, then compared one edge later.
   task automatic step(input string tag);
      int n_out, n_max;
      n_out = m_out;
      n_max = m_max;
      if (load)      n_out = int'(in);
      else if (down) n_out = (int'(rate) > m_out) ? 0 : m_out - int'(rate);
      else if (up)   n_out = (m_out >= m_max) ? m_max : m_out + 1;
      if (load_max == 2'b10) n_max = int'(in);
      @(posedge clk);
      #1;
      m_out = n_out;
      m_max = n_max;
      chk_all(tag);
   endtask

   // Reset asserted between edges must take effect without a clock.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      m_out = 0;
      m_max = ALL1;
      chk_all(tag);
      @(posedge clk);
      #1 chk_all({tag, ".held"});
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int exp33[7] = '{1, 2, 3, 4, 5, 5, 5};
      int exp34[4] = '{70, 40, 10, 0};

      m_out = 0;
      m_max = ALL1;
      async_reset("rst");
      chk("rst.max_literal", 32'(max), 32'd511);

      // Ceiling then saturating increment
      drive(0, 0, 0, 2'b10, 5, 0);   step("ceil_load");
      chk("ceil.max5", 32'(max), 32'd5);
      for (int i = 0; i < 7; i++) begin
         drive(1, 0, 0, 2'b00, 0, 0);
         step("sat_up");
         chk("sat_up.seq", 32'(out), 32'(exp33[i]));
         chk("sat_up.full", 32'(full), 32'(exp33[i] >= 5));
      end

      // Fire by rate down to zero
      drive(0, 0, 1, 2'b00, 100, 0); step("fire_load");
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 2'b00, 0, 30);
         step("fire");
         chk("fire.seq", 32'(out), 32'(exp34[i]));
      end
      chk("fire.empty", 32'(empty), 32'd1);

      // Priority: load beats down/up; down beats up
      drive(0, 0, 1, 2'b10, 20, 0);  step("pri_setmax");
      drive(0, 0, 1, 2'b00, 10, 0);  step("pri_set10");
      drive(1, 1, 1, 2'b00, 3, 5);   step("pri_load");
      chk("pri.load3", 32'(out), 32'd3);
      drive(1, 1, 0, 2'b00, 0, 2);   step("pri_down");
      chk("pri.down1", 32'(out), 32'd1);

      // Load above ceiling, clamp on up, then hold
      drive(0, 0, 1, 2'b00, 50, 0);  step("clamp_load");
      chk("clamp.load50", 32'(out), 32'd50);
      drive(1, 0, 0, 2'b00, 0, 0);   step("clamp_up");
      chk("clamp.to20", 32'(out), 32'd20);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 2'b01, 99, 0); step("hold");
      end
      chk("hold.20", 32'(out), 32'd20);

      // Load both registers in the same cycle
      drive(0, 0, 1, 2'b10, 77, 0);  step("both_load");

      // Async reset mid-count
      async_reset("rst2");
      for (int i = 0; i < 7; i++) begin
         drive(1, 0, 0, 2'b00, 0, 0); step("count7");
      end
      chk("count7.out", 32'(out), 32'd7);
      async_reset("rst_mid");
      chk("rst_mid.out0", 32'(out), 32'd0);
      drive(1, 0, 0, 2'b00, 0, 0);   step("resume");
      chk("resume.out1", 32'(out), 32'd1);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         int din, r;
         din = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ALL1) : $urandom_range(0, 40);
         r   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, ALL1) : $urandom_range(0, 12);
         drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), din, r);
         if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
         else                            step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
